mod_reduce: RTL and testbench
=============================

MOD_REDUCE -- requirements
Module: mod_reduce

Interface
REQ-001 The block SHALL have parameter DIVIDEND_W, default 64, meaning the width of the dividend input, which matches the exponentiation result width.
REQ-002 The block SHALL have parameter MOD_W, default 32, meaning the width of the modulus and remainder.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin a reduction; it is sampled only while idle.
REQ-006 The block SHALL have port dividend, input, DIVIDEND_W bits, the value to reduce; it is captured on the accepting edge.
REQ-007 The block SHALL have port modulus, input, MOD_W bits, the public prime p; it is captured on the accepting edge.
REQ-008 The block SHALL have port remainder, output, MOD_W bits, holding dividend mod modulus; it is registered.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse that marks remainder and err as valid.
REQ-010 The block SHALL have port busy, output, 1 bit, which is high while a reduction is in progress.
REQ-011 The block SHALL have port err, output, 1 bit, which is high when the captured modulus was zero; it is valid while done is high.

Function
REQ-012 The block SHALL implement the state machine IDLE -> CALC -> IDLE, with a zero-modulus short path IDLE -> IDLE.
REQ-013 In IDLE, on an edge where start=1, the block SHALL capture dividend and modulus, clear the partial remainder (MOD_W+1 bits) and the bit counter, and clear err.
REQ-014 On that accepting edge, if the captured modulus is nonzero, the block SHALL set busy=1 and enter CALC.
REQ-015 On that accepting edge, if the captured modulus is zero, the block SHALL stay in IDLE and set done=1, err=1 and remainder=0; latency is 1 cycle and busy stays 0.
REQ-016 In CALC, the block SHALL process one dividend bit per edge, MSB first, using restoring reduction: r = {r, next bit}; if r >= modulus then r = r - modulus.
REQ-017 The partial remainder SHALL never exceed modulus-1 after any step, and no information SHALL be lost to truncation.
REQ-018 CALC SHALL last exactly DIVIDEND_W edges.
REQ-019 On the DIVIDEND_W-th CALC edge, the block SHALL load remainder, pulse done=1, set busy=0 and return to IDLE.
REQ-020 Latency from the accepting edge to the done-high edge SHALL be DIVIDEND_W cycles (64 at default).
REQ-021 done SHALL be high for exactly one cycle per accepted request.
REQ-022 remainder and err SHALL hold their values until the next accepting edge.
REQ-023 A start asserted while busy=1 SHALL be ignored, with no queuing; changes on dividend or modulus during CALC SHALL have no effect.
REQ-024 A start asserted in the cycle where done=1 SHALL be accepted, since the state is already IDLE; this gives back-to-back operation.
REQ-025 A dividend smaller than modulus SHALL yield remainder = dividend, and modulus=1 SHALL yield remainder=0.
REQ-026 Outputs SHALL depend only on registered state; there is no combinational path from any input to any output.

Reset
REQ-027 While rst=0 at a rising edge, the block SHALL set state=IDLE, remainder=0, done=0, busy=0, err=0, and clear the counter and the partial remainder.
REQ-028 Reset during CALC SHALL abort the operation with no done pulse; the first start after rst returns to 1 SHALL be accepted normally.
REQ-029 rst SHALL take priority over start on the same edge.

Verification
REQ-030 The bench SHALL cover: dividend=823543 (7^7), modulus=23, start pulse -> done exactly 64 cycles later, remainder=5, err=0, busy high for 64 cycles.
REQ-031 The bench SHALL cover: dividend=64'hFFFF_FFFF_FFFF_FFFF, modulus=32'hFFFF_FFFF -> remainder=0 (because 2^64-1 = (2^32-1)(2^32+1)), err=0.
REQ-032 The bench SHALL cover: dividend=5, modulus=23 -> remainder=5; then dividend=100, modulus=1 -> remainder=0.
REQ-033 The bench SHALL cover: modulus=0, dividend=1234 -> done the next cycle, err=1, remainder=0, busy never high.
REQ-034 The bench SHALL cover: start re-pulsed at cycle 10 of CALC with new operands -> ignored, and the original result is delivered at cycle 64; a start in the done cycle with dividend=49, modulus=23 -> remainder=3 after a further 64 cycles.
REQ-035 The bench SHALL cover: rst=0 asserted at cycle 30 of CALC -> next cycle busy=0, done=0, remainder=0, and no done pulse follows; a subsequent request completes correctly.

Source files
------------

// File: rtl/mod_reduce.sv
// mod_reduce: serial restoring reduction of a DIVIDEND_W-bit value modulo a
// MOD_W-bit modulus, one dividend bit per clock, MSB first.
module mod_reduce #(
    parameter int unsigned DIVIDEND_W = 64,
    parameter int unsigned MOD_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [MOD_W-1:0]      modulus,
    output logic [MOD_W-1:0]      remainder,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    // Counter must reach DIVIDEND_W-1; partial remainder carries one guard bit.
    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int unsigned R_W   = MOD_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] div_q, div_d;
    logic [MOD_W-1:0]      mod_q, mod_d;
    logic [R_W-1:0]        r_q, r_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MOD_W-1:0]      rem_q, rem_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    // One restoring step: shift in next dividend bit, subtract modulus if it fits.
    logic [R_W:0] shift_c;
    logic [R_W:0] step_c;

    always_comb begin
        shift_c = {r_q, div_q[DIVIDEND_W-1]};
        if (shift_c >= {2'b00, mod_q}) begin
            step_c = shift_c - {2'b00, mod_q};
        end else begin
            step_c = shift_c;
        end
    end

    // Next-state and output logic for the IDLE/CALC controller.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        mod_d   = mod_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    div_d = dividend;
                    mod_d = modulus;
                    r_d   = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (modulus == '0) begin
                        // Division by zero: report immediately without entering CALC.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        rem_d  = '0;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = R_W'(step_c);
                div_d = {div_q[DIVIDEND_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    rem_d   = MOD_W'(step_c);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            mod_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign remainder = rem_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mod_reduce.sv
// tb_mod_reduce: directed and randomized requests against a % based model.
module tb_mod_reduce;

    localparam int unsigned DIVIDEND_W = 64;
    localparam int unsigned MOD_W      = 32;
    localparam int          BOUND      = 200;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [MOD_W-1:0]      modulus;
    logic [MOD_W-1:0]      remainder;
    logic                  done;
    logic                  busy;
    logic                  err;

    int n_cmp = 0;
    int n_err = 0;

    mod_reduce #(
        .DIVIDEND_W(DIVIDEND_W),
        .MOD_W     (MOD_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .modulus  (modulus),
        .remainder(remainder),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MOD_W-1:0] ref_mod(input logic [63:0] d, input logic [MOD_W-1:0] m);
        if (m == '0) return '0;
        return MOD_W'(d % {32'd0, m});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; lat counts edges after the accepting edge until done
    // is seen (0 for a zero modulus, DIVIDEND_W otherwise). A stray start with
    // random operands is injected when lat equals repulse_at.
    task automatic run_req(input logic [63:0] d, input logic [MOD_W-1:0] m,
                           input int repulse_at, input string tag);
        int lat;
        int busy_n;
        start    = 1'b1;
        dividend = d;
        modulus  = m;
        tick();
        start = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < BOUND) begin
            busy_n += int'(busy);
            if (lat == repulse_at) begin
                start    = 1'b1;
                dividend = {$urandom(), $urandom()};
                modulus  = $urandom() | 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"},  64'(lat),    (m == '0) ? 64'd0 : 64'(DIVIDEND_W));
        check({tag, "_rem"},  64'(remainder), 64'(ref_mod(d, m)));
        check({tag, "_err"},  64'(err),    64'(m == '0));
        check({tag, "_busyn"}, 64'(busy_n), (m == '0) ? 64'd0 : 64'(DIVIDEND_W));
        check({tag, "_busy0"}, 64'(busy),  64'd0);
    endtask

    // done must drop on the cycle after its pulse.
    task automatic check_pulse_end(input string tag);
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [63:0] rd;
        logic [MOD_W-1:0] rm;

        rst = 1'b0; start = 1'b0; dividend = '0; modulus = '0;
        repeat (3) tick();
        check("rst_rem",  64'(remainder), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err",  64'(err),  64'd0);

        // Reset beats a start (zero modulus would otherwise pulse done).
        start = 1'b1; modulus = '0; dividend = 64'd7;
        tick();
        start = 1'b0;
        check("rstprio_done", 64'(done), 64'd0);
        check("rstprio_err",  64'(err),  64'd0);
        rst = 1'b1;
        tick();

        run_req(64'd823543, 32'd23, -1, "pow77");
        check("pow77_const", 64'(remainder), 64'd5);
        check_pulse_end("pow77");

        run_req(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, -1, "allones");
        check("allones_const", 64'(remainder), 64'd0);
        check_pulse_end("allones");

        run_req(64'd5, 32'd23, -1, "small");
        check_pulse_end("small");
        run_req(64'd100, 32'd1, -1, "mod1");
        check_pulse_end("mod1");

        run_req(64'd1234, 32'd0, -1, "mod0");
        check_pulse_end("mod0");

        // Ignored restart mid-CALC, then a back-to-back start in the done cycle.
        run_req(64'd823543, 32'd23, 10, "repulse");
        run_req(64'd49, 32'd23, -1, "b2b");
        check("b2b_const", 64'(remainder), 64'd3);
        check_pulse_end("b2b");

        // Abort during CALC; no late done pulse may appear.
        start = 1'b1; dividend = 64'hDEAD_BEEF_0123_4567; modulus = 32'd1_000_003;
        tick();
        start = 1'b0;
        repeat (30) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rem",  64'(remainder), 64'd0);
        done_seen = 0;
        repeat (80) begin
            tick();
            done_seen += int'(done);
        end
        check("abort_nodone", 64'(done_seen), 64'd0);
        run_req(64'd823543, 32'd23, -1, "after_abort");
        check_pulse_end("after_abort");

        // Randomized operands, including small, zero and near-full moduli.
        for (int i = 0; i < 20; i++) begin
            rd = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0: rm = $urandom();
                1: rm = MOD_W'($urandom_range(1, 30));
                2: rm = '0;
                3: rm = 32'hFFFF_FFFF - MOD_W'($urandom_range(0, 7));
                default: begin
                    rm = $urandom() | 32'd1;
                    rd = 64'($urandom_range(0, 1000));
                end
            endcase
            run_req(rd, rm, -1, "rand");
            if ($urandom_range(0, 1) == 1) check_pulse_end("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
